// File: rtl/copperv_bus_arbiter.sv
// copperv_bus_arbiter: merges the copperv instruction-read port and the data
// read/write ports onto one valid/ready memory bus, one transaction at a time.
// Optional feature macro: COPPERV_ARB_RR_EN (round-robin grant instead of the
// fixed DW > DR > I priority).
module copperv_bus_arbiter #(
    parameter int BUS_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    // core instruction read
    input  logic                 i_raddr_valid,
    input  logic [BUS_WIDTH-1:0] i_raddr,
    output logic                 i_raddr_ready,
    output logic                 i_rdata_valid,
    output logic [BUS_WIDTH-1:0] i_rdata,
    input  logic                 i_rdata_ready,
    // core data read
    input  logic                 d_raddr_valid,
    input  logic [BUS_WIDTH-1:0] d_raddr,
    output logic                 d_raddr_ready,
    output logic                 d_rdata_valid,
    output logic [BUS_WIDTH-1:0] d_rdata,
    input  logic                 d_rdata_ready,
    // core data write
    input  logic                 d_waddr_valid,
    input  logic [BUS_WIDTH-1:0] d_waddr,
    output logic                 d_waddr_ready,
    input  logic                 d_wdata_valid,
    input  logic [BUS_WIDTH-1:0] d_wdata,
    output logic                 d_wdata_ready,
    // memory side
    output logic                 m_raddr_valid,
    output logic [BUS_WIDTH-1:0] m_raddr,
    input  logic                 m_raddr_ready,
    input  logic                 m_rdata_valid,
    input  logic [BUS_WIDTH-1:0] m_rdata,
    output logic                 m_rdata_ready,
    output logic                 m_waddr_valid,
    output logic [BUS_WIDTH-1:0] m_waddr,
    input  logic                 m_waddr_ready,
    output logic                 m_wdata_valid,
    output logic [BUS_WIDTH-1:0] m_wdata,
    input  logic                 m_wdata_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RADDR = 2'd1,
        RDATA = 2'd2,
        WRITE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SRC_I  = 2'd0,
        SRC_DR = 2'd1,
        SRC_DW = 2'd2
    } src_t;

    state_t               state, state_next;
    src_t                 src, gnt;
    logic                 gnt_valid;
    logic [BUS_WIDTH-1:0] addr_q, wdata_q;
    logic                 waddr_done, wdata_done;
    logic                 req_i, req_dr, req_dw;

    // a write is only eligible once both of its channels are presented
    assign req_i  = i_raddr_valid;
    assign req_dr = d_raddr_valid;
    assign req_dw = d_waddr_valid && d_wdata_valid;

`ifdef COPPERV_ARB_RR_EN
    src_t last_q;

    // round-robin: search starts at the requester after the last winner
    always_comb begin
        gnt       = SRC_I;
        gnt_valid = req_i || req_dr || req_dw;
        case (last_q)
            SRC_I: begin
                if (req_dr)      gnt = SRC_DR;
                else if (req_dw) gnt = SRC_DW;
                else             gnt = SRC_I;
            end
            SRC_DR: begin
                if (req_dw)      gnt = SRC_DW;
                else if (req_i)  gnt = SRC_I;
                else             gnt = SRC_DR;
            end
            default: begin
                if (req_i)       gnt = SRC_I;
                else if (req_dr) gnt = SRC_DR;
                else             gnt = SRC_DW;
            end
        endcase
    end

    // last-grant pointer follows every accepted request
    always_ff @(posedge clk) begin
        if (rst)
            last_q <= SRC_I;
        else if (state == IDLE && gnt_valid)
            last_q <= gnt;
    end
`else
    // fixed priority: write, then data read, then instruction read
    always_comb begin
        gnt_valid = req_i || req_dr || req_dw;
        if (req_dw)      gnt = SRC_DW;
        else if (req_dr) gnt = SRC_DR;
        else             gnt = SRC_I;
    end
`endif

    // next state and all handshake outputs
    always_comb begin
        state_next    = state;
        i_raddr_ready = 1'b0;
        d_raddr_ready = 1'b0;
        d_waddr_ready = 1'b0;
        d_wdata_ready = 1'b0;
        i_rdata_valid = 1'b0;
        i_rdata       = '0;
        d_rdata_valid = 1'b0;
        d_rdata       = '0;
        m_raddr_valid = 1'b0;
        m_raddr       = addr_q;
        m_rdata_ready = 1'b0;
        m_waddr_valid = 1'b0;
        m_waddr       = addr_q;
        m_wdata_valid = 1'b0;
        m_wdata       = wdata_q;
        case (state)
            IDLE: begin
                // no acceptance while reset is held: the grant would be lost
                if (gnt_valid && !rst) begin
                    case (gnt)
                        SRC_I: begin
                            i_raddr_ready = 1'b1;
                            state_next    = RADDR;
                        end
                        SRC_DR: begin
                            d_raddr_ready = 1'b1;
                            state_next    = RADDR;
                        end
                        default: begin
                            d_waddr_ready = 1'b1;
                            d_wdata_ready = 1'b1;
                            state_next    = WRITE;
                        end
                    endcase
                end
            end
            RADDR: begin
                m_raddr_valid = 1'b1;
                if (m_raddr_ready)
                    state_next = RDATA;
            end
            RDATA: begin
                if (src == SRC_I) begin
                    m_rdata_ready = i_rdata_ready;
                    i_rdata_valid = m_rdata_valid;
                    i_rdata       = m_rdata;
                end else begin
                    m_rdata_ready = d_rdata_ready;
                    d_rdata_valid = m_rdata_valid;
                    d_rdata       = m_rdata;
                end
                if (m_rdata_valid && m_rdata_ready)
                    state_next = IDLE;
            end
            default: begin
                m_waddr_valid = !waddr_done;
                m_wdata_valid = !wdata_done;
                if ((waddr_done || m_waddr_ready) && (wdata_done || m_wdata_ready))
                    state_next = IDLE;
            end
        endcase
    end

    // state, latched request payload and write-channel completion flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            src        <= SRC_I;
            addr_q     <= '0;
            wdata_q    <= '0;
            waddr_done <= 1'b0;
            wdata_done <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && gnt_valid) begin
                src <= gnt;
                case (gnt)
                    SRC_I:  addr_q <= i_raddr;
                    SRC_DR: addr_q <= d_raddr;
                    default: begin
                        addr_q     <= d_waddr;
                        wdata_q    <= d_wdata;
                        waddr_done <= 1'b0;
                        wdata_done <= 1'b0;
                    end
                endcase
            end
            if (state == WRITE) begin
                if (m_waddr_valid && m_waddr_ready) waddr_done <= 1'b1;
                if (m_wdata_valid && m_wdata_ready) wdata_done <= 1'b1;
            end
        end
    end

endmodule
